mac_array_seq: RTL

Controller for the weight-stationary systolic MAC array. It runs a three-phase job: load weights row by row, stream input vectors into row 0, then drain the array pipeline. It drives the per-row weight enables, the row-0 input enable, `mode_N` and the global `clk_ws_enable` stall gate. Inter-row input propagation is left to the MACs' own `next_en_row` chaining. It sits between the weight/input staging buffers and the array, with a start/done handshake to the top-level layer FSM.

---
 rtl/mac_seq_pkg.sv | 20 ++
 rtl/mac_array_seq_if.sv | 31 +++
 rtl/mac_seq_perf.sv | 22 ++
 rtl/mac_array_seq.sv | 114 +++++++++++
 4 files changed

// File: rtl/mac_seq_pkg.sv
// Shared types and helpers for the systolic MAC array sequencer.
package mac_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOADW,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } mac_seq_state_t;

    localparam int unsigned MAC_PIPE_DEPTH = 3;
    // Drain length is mode_N plus this pad (pipeline depth minus one).
    localparam int unsigned DRAIN_PAD = MAC_PIPE_DEPTH - 1;

    function automatic int unsigned clamp_n(input int unsigned n, input int unsigned rows);
        return ((n == 0) || (n > rows)) ? rows : n;
    endfunction

endpackage

// File: rtl/mac_array_seq_if.sv
// Handshake bundle between the layer FSM / staging buffers and the array sequencer.
interface mac_array_seq_if #(
    parameter int unsigned ROWS = 16,
    parameter int unsigned NW   = 5,
    parameter int unsigned TW   = 16
);
    logic            start;
    logic [NW-1:0]   cfg_n;
    logic [TW-1:0]   cfg_tiles;
    logic            w_valid;
    logic            w_ready;
    logic            in_valid;
    logic            in_ready;
    logic            out_stall;
    logic            clk_ws_enable;
    logic [ROWS-1:0] enW;
    logic            enI0;
    logic [NW-1:0]   mode_N;
    logic            busy;
    logic            done;

    modport master (
        output start, cfg_n, cfg_tiles, w_valid, in_valid, out_stall,
        input  w_ready, in_ready, clk_ws_enable, enW, enI0, mode_N, busy, done
    );

    modport slave (
        input  start, cfg_n, cfg_tiles, w_valid, in_valid, out_stall,
        output w_ready, in_ready, clk_ws_enable, enW, enI0, mode_N, busy, done
    );
endinterface

// File: rtl/mac_seq_perf.sv
// Saturating busy/stall cycle counters for the array sequencer.
module mac_seq_perf (
    input  logic        clk,
    input  logic        rstn,
    input  logic        clear,
    input  logic        busy,
    input  logic        stall,
    output logic [31:0] perf_busy,
    output logic [31:0] perf_stall
);
    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            perf_busy  <= '0;
            perf_stall <= '0;
        end else begin
            if (busy && (perf_busy != '1))
                perf_busy <= perf_busy + 32'd1;
            if (busy && stall && (perf_stall != '1))
                perf_stall <= perf_stall + 32'd1;
        end
    end
endmodule

// File: rtl/mac_array_seq.sv
// Weight-stationary MAC array sequencer: load weights, stream inputs, drain.
// Optional perf counters enabled by defining MAC_SEQ_PERF_CNT_EN.
module mac_array_seq
    import mac_seq_pkg::*;
#(
    parameter int unsigned ROWS = 16,
    parameter int unsigned NW   = 5,
    parameter int unsigned TW   = 16
) (
    input logic            CLK,
    input logic            RSTN,
    mac_array_seq_if.slave bus
`ifdef MAC_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]    perf_busy,
    output logic [31:0]    perf_stall
`endif
);
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    mac_seq_state_t state;
    logic [RW-1:0]  row_idx;
    logic [TW-1:0]  tile_cnt;
    logic [TW-1:0]  tiles;
    logic [NW:0]    drain_cnt;
    logic [NW-1:0]  mode_n;

    logic adv;
    logic w_ready;
    logic in_ready;
    logic w_fire;
    logic last_row;
    logic last_tile;
    logic last_drain;

    assign adv       = ~bus.out_stall;
    assign w_ready   = adv & (state == S_LOADW);
    assign in_ready  = adv & (state == S_STREAM);
    assign w_fire    = bus.w_valid & w_ready;

    assign last_row   = (NW'(row_idx) == (mode_n - NW'(1)));
    assign last_tile  = (tile_cnt == (tiles - TW'(1)));
    assign last_drain = ((drain_cnt + (NW+1)'(1)) == ((NW+1)'(mode_n) + (NW+1)'(DRAIN_PAD)));

    assign bus.clk_ws_enable = adv;
    assign bus.w_ready       = w_ready;
    assign bus.in_ready      = in_ready;
    // Enables stay combinational so they line up with the buffer data beat.
    assign bus.enW           = w_fire ? (ROWS'(1) << row_idx) : '0;
    assign bus.enI0          = bus.in_valid & in_ready;
    assign bus.mode_N        = mode_n;
    assign bus.busy          = (state != S_IDLE);
    assign bus.done          = (state == S_DONE);

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state     <= S_IDLE;
            mode_n    <= '0;
            tiles     <= '0;
            row_idx   <= '0;
            tile_cnt  <= '0;
            drain_cnt <= '0;
        end else if (adv) begin
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state     <= S_LOADW;
                        mode_n    <= NW'(clamp_n(32'(bus.cfg_n), ROWS));
                        tiles     <= bus.cfg_tiles;
                        row_idx   <= '0;
                        tile_cnt  <= '0;
                        drain_cnt <= '0;
                    end
                end
                S_LOADW: begin
                    if (bus.w_valid) begin
                        row_idx <= row_idx + RW'(1);
                        if (last_row)
                            state <= (tiles == '0) ? S_DRAIN : S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (bus.in_valid) begin
                        tile_cnt <= tile_cnt + TW'(1);
                        if (last_tile)
                            state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    drain_cnt <= drain_cnt + (NW+1)'(1);
                    if (last_drain)
                        state <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef MAC_SEQ_PERF_CNT_EN
    mac_seq_perf u_perf (
        .clk        (CLK),
        .rstn       (RSTN),
        .clear      ((state == S_IDLE) & bus.start & adv),
        .busy       (state != S_IDLE),
        .stall      (bus.out_stall),
        .perf_busy  (perf_busy),
        .perf_stall (perf_stall)
    );
`endif

endmodule
